// File: rtl/gpr_delta_tracer.sv
// Tracks x1..x31 against a shadow image and queues one {index, value} write
// event per cycle for changed registers, drained through a valid/ready port.
//
// state | meaning
// IDLE  | tracing off, no events generated, FIFO still drains
// PRIME | load shadow from the tapped image, clear overrun
// RUN   | compare image to shadow, push lowest changed register
module gpr_delta_tracer #(
  parameter int NREG       = 31,
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          trace_en,
  input  logic [NREG*XLEN-1:0]          gpr_flat,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [4:0]                    ev_idx,
  output logic [XLEN-1:0]               ev_data,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overrun
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN
  } state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0] shadow [NREG];
  logic [XLEN-1:0] prev   [NREG];
  logic [NREG-1:0] prev_mm;
  logic [NREG-1:0] mismatch;
  logic [NREG-1:0] push_oh;
  logic [4:0]      sel;
  logic            found;
  logic            push;
  logic            pop;
  logic            ovr_hit;
  logic [XLEN-1:0] push_data;

  logic [4:0]      mem_idx  [FIFO_DEPTH];
  logic [XLEN-1:0] mem_data [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trace_en) state_nxt = S_PRIME;
      S_PRIME: state_nxt = S_RUN;
      S_RUN:   if (!trace_en) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mismatch = '0;
    found    = 1'b0;
    sel      = '0;
    for (int k = 0; k < NREG; k++) begin
      mismatch[k] = (state == S_RUN) && (gpr_flat[k*XLEN +: XLEN] != shadow[k]);
    end
    for (int k = NREG - 1; k >= 0; k--) begin
      if (mismatch[k]) begin
        found = 1'b1;
        sel   = k[4:0];
      end
    end
  end

  assign pop       = ev_valid && ev_ready;
  // Pushing is also gated by trace_en so a change in the disabling cycle is dropped.
  assign push      = (state == S_RUN) && trace_en && found && ((count != FULL) || pop);
  assign push_data = gpr_flat[sel*XLEN +: XLEN];

  always_comb begin
    push_oh = '0;
    if (push) push_oh[sel] = 1'b1;
    ovr_hit = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      if (prev_mm[k] && (gpr_flat[k*XLEN +: XLEN] != prev[k]) && !push_oh[k]) ovr_hit = 1'b1;
    end
    if (state != S_RUN) ovr_hit = 1'b0;
  end

  // prev_mm marks registers still pending after this cycle's push.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREG; k++) begin
        shadow[k] <= '0;
        prev[k]   <= '0;
      end
      prev_mm <= '0;
      overrun <= 1'b0;
    end else begin
      for (int k = 0; k < NREG; k++) prev[k] <= gpr_flat[k*XLEN +: XLEN];
      prev_mm <= mismatch & ~push_oh;
      if (state == S_PRIME) begin
        for (int k = 0; k < NREG; k++) shadow[k] <= gpr_flat[k*XLEN +: XLEN];
        overrun <= 1'b0;
      end else if (state == S_RUN) begin
        if (push)    shadow[sel] <= push_data;
        if (ovr_hit) overrun     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_idx[i]  <= '0;
        mem_data[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_idx[wr_ptr]  <= sel + 5'd1;
        mem_data[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign ev_count = count;
  assign ev_valid = (count != '0);
  assign ev_idx   = ev_valid ? mem_idx[rd_ptr]  : '0;
  assign ev_data  = ev_valid ? mem_data[rd_ptr] : '0;

endmodule

// File: tb/tb_gpr_delta_tracer.sv
// Bench for gpr_delta_tracer: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an event-queue model.
module tb_gpr_delta_tracer;

  localparam int NREG  = 31;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 trace_en = 1'b0;
  logic                 ev_ready = 1'b0;
  logic [NREG*XLEN-1:0] gpr_flat = '0;
  wire                  ev_valid;
  wire  [4:0]           ev_idx;
  wire  [XLEN-1:0]      ev_data;
  wire  [3:0]           ev_count;
  wire                  overrun;

  int checks = 0;
  int errors = 0;

  gpr_delta_tracer #(.NREG(NREG), .XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .trace_en (trace_en),
    .gpr_flat (gpr_flat),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_idx   (ev_idx),
    .ev_data  (ev_data),
    .ev_count (ev_count),
    .overrun  (overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an event queue plus the last-emitted value per register.
  typedef struct {
    int          idx;
    logic [31:0] data;
  } ev_t;

  ev_t         q[$];
  int          m_mode;   // 0 disabled, 1 priming, 2 tracing
  logic [31:0] m_shadow [NREG];
  logic [31:0] m_prev   [NREG];
  bit          m_pend   [NREG];
  bit          m_ovr;

  function automatic logic [31:0] slot(int k);
    return gpr_flat[k*XLEN +: XLEN];
  endfunction

  always @(posedge clock or negedge reset_n) begin : model
    bit  pop, push, pushed_k;
    int  sel;
    bit  nxt_pend [NREG];
    ev_t e;
    if (!reset_n) begin
      q.delete();
      m_mode = 0;
      m_ovr  = 0;
      for (int k = 0; k < NREG; k++) begin
        m_shadow[k] = '0;
        m_prev[k]   = '0;
        m_pend[k]   = 0;
      end
    end else begin
      pop  = (q.size() > 0) && ev_ready;
      push = 0;
      sel  = -1;
      for (int k = 0; k < NREG; k++) nxt_pend[k] = 0;
      if (m_mode == 2) begin
        for (int k = 0; k < NREG; k++)
          if (sel < 0 && slot(k) != m_shadow[k]) sel = k;
        push = trace_en && (sel >= 0) && ((q.size() < DEPTH) || pop);
        for (int k = 0; k < NREG; k++) begin
          pushed_k = push && (k == sel);
          if (m_pend[k] && slot(k) != m_prev[k] && !pushed_k) m_ovr = 1;
          nxt_pend[k] = (slot(k) != m_shadow[k]) && !pushed_k;
        end
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        e.idx  = sel + 1;
        e.data = slot(sel);
        q.push_back(e);
        m_shadow[sel] = slot(sel);
      end
      if (m_mode == 1) begin
        for (int k = 0; k < NREG; k++) m_shadow[k] = slot(k);
        m_ovr = 0;
      end
      for (int k = 0; k < NREG; k++) begin
        m_pend[k] = nxt_pend[k];
        m_prev[k] = slot(k);
      end
      case (m_mode)
        0:       if (trace_en) m_mode = 1;
        1:       m_mode = 2;
        default: if (!trace_en) m_mode = 0;
      endcase
    end
  end

  always @(negedge clock) begin : compare
    int          exp_idx;
    logic [31:0] exp_data;
    exp_idx  = (q.size() > 0) ? q[0].idx : 0;
    exp_data = (q.size() > 0) ? q[0].data : '0;
    chk("m_valid", ev_valid, q.size() != 0);
    chk("m_count", ev_count, q.size());
    chk("m_idx", ev_idx, exp_idx);
    chk("m_data", ev_data, exp_data);
    chk("m_overrun", overrun, m_ovr);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_x(int idx, logic [31:0] v);
    gpr_flat[(idx-1)*XLEN +: XLEN] = v;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int burst;
    int hot;
    int n;
    logic [31:0] v;

    repeat (3) tick();
    chk("rst_valid", ev_valid, 0);
    chk("rst_count", ev_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_idx", ev_idx, 0);
    chk("rst_data", ev_data, 0);
    reset_n  = 1'b1;
    trace_en = 1'b1;
    tick();
    tick();

    // 1: single change, one-cycle latency
    set_x(5, 32'hDEADBEEF);
    tick();
    chk("t1_valid", ev_valid, 1);
    chk("t1_idx", ev_idx, 5);
    chk("t1_data", ev_data, 32'hDEADBEEF);
    chk("t1_count", ev_count, 1);

    // 2: three simultaneous changes drain lowest index first
    ev_ready = 1'b1;
    set_x(3, 1);
    set_x(7, 2);
    set_x(31, 3);
    tick();
    chk("t2_idx_a", ev_idx, 3);
    chk("t2_data_a", ev_data, 1);
    tick();
    chk("t2_idx_b", ev_idx, 7);
    chk("t2_data_b", ev_data, 2);
    tick();
    chk("t2_idx_c", ev_idx, 31);
    chk("t2_data_c", ev_data, 3);
    tick();
    chk("t2_empty", ev_valid, 0);

    // 3: nine changes against a stalled consumer
    ev_ready = 1'b0;
    for (int i = 1; i <= 9; i++) set_x(i, 32'h100 + i);
    repeat (8) tick();
    chk("t3_full", ev_count, 8);
    tick();
    chk("t3_sat", ev_count, 8);
    chk("t3_no_ovr", overrun, 0);
    ev_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      chk("t3_idx", ev_idx, i);
      chk("t3_data", ev_data, 32'h100 + i);
      tick();
    end
    chk("t3_empty", ev_valid, 0);

    // 4: pending register overwritten while full
    ev_ready = 1'b0;
    for (int i = 11; i <= 18; i++) set_x(i, 32'h200 + i);
    repeat (8) tick();
    chk("t4_full", ev_count, 8);
    set_x(10, 1);
    tick();
    set_x(10, 2);
    tick();
    set_x(10, 3);
    tick();
    chk("t4_ovr", overrun, 1);
    ev_ready = 1'b1;
    for (int i = 11; i <= 18; i++) begin
      chk("t4_idx", ev_idx, i);
      tick();
    end
    chk("t4_x10_idx", ev_idx, 10);
    chk("t4_x10_data", ev_data, 3);
    tick();
    chk("t4_empty", ev_valid, 0);
    chk("t4_ovr_sticky", overrun, 1);

    // 5: disable with a same-cycle change, then re-enable
    trace_en = 1'b0;
    set_x(4, 32'h444);
    tick();
    chk("t5_no_ev", ev_valid, 0);
    tick();
    tick();
    chk("t5_idle_no_ev", ev_valid, 0);
    chk("t5_ovr_held", overrun, 1);
    trace_en = 1'b1;
    tick();
    tick();
    chk("t5_ovr_clr", overrun, 0);
    tick();
    chk("t5_no_stale", ev_valid, 0);
    set_x(20, 32'h2020);
    tick();
    chk("t5_valid", ev_valid, 1);
    chk("t5_idx", ev_idx, 20);
    chk("t5_data", ev_data, 32'h2020);
    tick();
    chk("t5_empty", ev_valid, 0);

    // 6: reset while events are queued and being accepted
    ev_ready = 1'b0;
    for (int i = 21; i <= 25; i++) set_x(i, 32'h300 + i);
    repeat (5) tick();
    chk("t6_count", ev_count, 5);
    ev_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_valid", ev_valid, 0);
    chk("t6_count0", ev_count, 0);
    chk("t6_idx", ev_idx, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_quiet", ev_valid, 0);
    end

    // Randomized traffic against the model
    burst = 0;
    hot   = $urandom_range(1, 31);
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) reset_n = 1'b0;
      if (c == 1502) reset_n = 1'b1;
      if (burst > 0) burst--;
      else if ($urandom_range(0, 40) == 0) burst = $urandom_range(5, 20);
      ev_ready = (burst == 0) && ($urandom_range(0, 3) != 0);
      if (trace_en) begin
        if ($urandom_range(0, 150) == 0) trace_en = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        trace_en = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
          v = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 3);
          set_x($urandom_range(1, 31), v);
        end
      end
      if ($urandom_range(0, 5) == 0) set_x(hot, $urandom);
      tick();
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
